// File: rtl/serial_subtractor_pkg.sv
// Shared constants, state encoding and helpers for the serial subtractor.
// The borrow chain is a carry chain on an inverted subtrahend.
package serial_subtractor_pkg;

  localparam int SLICE_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    return {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/Done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
  parameter int SLICES = 2
);
  localparam int W = serial_subtractor_pkg::SLICE_W * SLICES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;

  modport master (
    output start, a, b, bin,
    input  ready, done, diff, bout, zero
  );

  modport slave (
    input  start, a, b, bin,
    output ready, done, diff, bout, zero
  );

endinterface

// File: rtl/subtract_slice5.sv
// Combinational 5-bit subtract slice: d = a - b - bin, bout = 1 iff a < b + bin.
// A ripple of full-adder cells on ~b with carry-in ~bin; borrow-out is the inverted carry.
module subtract_slice5
  import serial_subtractor_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);

  logic c;
  logic [1:0] fa;

  always_comb begin
    d  = '0;
    c  = ~bin;
    fa = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      fa   = full_add(a[i], ~b[i], c);
      d[i] = fa[0];
      c    = fa[1];
    end
    bout = ~c;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor sharing one 5-bit borrow slice across SLICES slices.
// Results and the Done pulse appear together in the DONE cycle.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int SLICES = 2
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int IDX_W = idx_width(SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  state_e state_q, state_d;
  logic [SLICES-1:0][SLICE_W-1:0] a_q, a_d;
  logic [SLICES-1:0][SLICE_W-1:0] b_q, b_d;
  logic [SLICES-1:0][SLICE_W-1:0] work_q, work_d;
  logic [SLICES-1:0][SLICE_W-1:0] diff_q, diff_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic borrow_q, borrow_d;
  logic done_q, done_d;
  logic bout_q, bout_d;
  logic zero_q, zero_d;

  logic [SLICE_W-1:0] slice_d;
  logic               slice_bout;

  subtract_slice5 u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .bin  (borrow_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
    bout_d   = bout_q;
    zero_d   = zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          work_d   = '0;
          idx_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d[idx_q] = slice_d;
        borrow_d      = slice_bout;
        if (idx_q == LAST_IDX) begin
          // Publish on entry to DONE so the results are valid alongside the Done pulse.
          diff_d  = work_d;
          bout_d  = slice_bout;
          zero_d  = (work_d == '0);
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed corner cases plus a back-to-back randomized stream
// compared against plain integer arithmetic.
module tb_serial_subtractor;

  localparam int SLICES = 2;
  localparam int W      = 5 * SLICES;
  localparam int MOD    = 1 << W;
  localparam int N_RAND = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.SLICES(SLICES)) bus ();

  serial_subtractor #(.SLICES(SLICES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_diff(input int a, input int b, input int bin);
    return (a - b - bin + 2 * MOD) % MOD;
  endfunction

  function automatic int ref_bout(input int a, input int b, input int bin);
    return (a < b + bin) ? 1 : 0;
  endfunction

  task automatic run_op(input string tag, input int a, input int b, input int bin, input bit disturb);
    int dones;
    logic [W-1:0] prev_diff;
    @(negedge clk);
    prev_diff = bus.diff;
    bus.a     = W'(a);
    bus.b     = W'(b);
    bus.bin   = bin[0];
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (disturb) begin
      bus.a   = W'($urandom_range(0, MOD - 1));
      bus.b   = W'($urandom_range(0, MOD - 1));
      bus.bin = 1'($urandom_range(0, 1));
    end
    dones = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) check({tag, "_ready_low"}, 32'(bus.ready), 32'd0);
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          check({tag, "_latency"}, 32'(i), 32'(SLICES + 1));
          check({tag, "_diff"}, 32'(bus.diff), 32'(ref_diff(a, b, bin)));
          check({tag, "_bout"}, 32'(bus.bout), 32'(ref_bout(a, b, bin)));
          check({tag, "_zero"}, 32'(bus.zero), 32'(ref_diff(a, b, bin) == 0));
        end
      end else if (dones == 0) begin
        check({tag, "_hold"}, 32'(bus.diff), 32'(prev_diff));
      end
      if (disturb && i == 1) bus.start = 1'b1;
      if (disturb && i == 2) bus.start = 1'b0;
    end
    check({tag, "_done_count"}, 32'(dones), 32'd1);
  endtask

  typedef struct {
    int diff;
    int bout;
  } exp_t;

  initial begin
    exp_t exp_q[$];
    exp_t e;
    int launched;
    int last_done;
    int dones_in_rst;
    int ra, rb, rbin;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_diff",  32'(bus.diff),  32'd0);
    check("rst_bout",  32'(bus.bout),  32'd0);
    check("rst_zero",  32'(bus.zero),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("basic",    700, 300, 0, 1'b0);
    run_op("neg",        5,   6, 0, 1'b0);
    run_op("allones",    0,   0, 1, 1'b0);
    run_op("xslice",    32,   1, 0, 1'b0);
    run_op("xzero",    512, 511, 1, 1'b0);
    run_op("eq",       100, 100, 0, 1'b0);
    run_op("disturb",  123,  45, 1, 1'b1);

    // Asynchronous reset landing between edges of a RUN cycle.
    @(negedge clk);
    bus.a = W'(700); bus.b = W'(300); bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.ready), 32'd1);
    check("mid_rst_done",  32'(bus.done),  32'd0);
    check("mid_rst_diff",  32'(bus.diff),  32'd0);
    check("mid_rst_bout",  32'(bus.bout),  32'd0);
    check("mid_rst_zero",  32'(bus.zero),  32'd0);
    dones_in_rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      if (bus.done) dones_in_rst++;
    end
    check("mid_rst_no_done", 32'(dones_in_rst), 32'd0);
    run_op("post_rst", 10, 3, 0, 1'b0);

    // Back-to-back stream with Start held high.
    launched  = 0;
    last_done = -1;
    for (int cyc = 0; cyc < N_RAND * 4 + 50; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream_diff", 32'(bus.diff), 32'(e.diff));
          check("stream_bout", 32'(bus.bout), 32'(e.bout));
          if (last_done >= 0) check("stream_period", 32'(cyc - last_done), 32'd4);
          last_done = cyc;
        end
      end
      if (bus.ready) begin
        if (launched < N_RAND) begin
          ra   = $urandom_range(0, MOD - 1);
          rb   = $urandom_range(0, MOD - 1);
          rbin = $urandom_range(0, 1);
          bus.a     = W'(ra);
          bus.b     = W'(rb);
          bus.bin   = rbin[0];
          bus.start = 1'b1;
          e.diff = ref_diff(ra, rb, rbin);
          e.bout = ref_bout(ra, rb, rbin);
          exp_q.push_back(e);
          launched++;
        end else begin
          bus.start = 1'b0;
        end
      end
      if (launched == N_RAND && exp_q.size() == 0) break;
    end
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    check("stream_launched", 32'(launched), 32'(N_RAND));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
